// File: rtl/fas_pkg.sv
// rtl/fas_pkg.sv - shared constants, bin struct and FSM states for fft_frame_sched
package fas_pkg;

    localparam int NBINS = 16;
    localparam int DW    = 32;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
    } bin_t;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/fft_frame_sched_if.sv
// rtl/fft_frame_sched_if.sv - bin output stream of fft_frame_sched (valid/ready handshake)
interface fft_frame_sched_if #(
    parameter int DW = 32
) ();

    logic          bin_valid;
    logic          bin_ready;
    logic [DW-1:0] bin_data;
    logic [3:0]    bin_idx;
    logic          bin_last;

    modport master (
        output bin_valid,
        output bin_data,
        output bin_idx,
        output bin_last,
        input  bin_ready
    );

    modport slave (
        input  bin_valid,
        input  bin_data,
        input  bin_idx,
        input  bin_last,
        output bin_ready
    );

endinterface

// File: rtl/fft_frame_buf.sv
// rtl/fft_frame_buf.sv - one FFT frame of storage: parallel write of all bins, indexed read
module fft_frame_buf #(
    parameter int DW    = 32,
    parameter int NBINS = 16
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [NBINS-1:0][DW-1:0]      wdata,
    input  logic [$clog2(NBINS)-1:0]      ridx,
    output logic [DW-1:0]                 rdata
);

    logic [DW-1:0] mem [NBINS];

    // Contents are not reset; the scheduler's full flags decide what is meaningful.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < NBINS; k++) begin
                mem[k] <= wdata[k];
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/fft_frame_sched.sv
// rtl/fft_frame_sched.sv - ping/pong FFT frame scheduler serialising 16 parallel bins; FAS_DROP_CNT_EN adds drop_cnt
module fft_frame_sched #(
    parameter int DW     = fas_pkg::DW,
    parameter int NBINS  = fas_pkg::NBINS,
    parameter int DROP_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fft_valid,
    input  logic [DW-1:0]       fft_d0,
    input  logic [DW-1:0]       fft_d1,
    input  logic [DW-1:0]       fft_d2,
    input  logic [DW-1:0]       fft_d3,
    input  logic [DW-1:0]       fft_d4,
    input  logic [DW-1:0]       fft_d5,
    input  logic [DW-1:0]       fft_d6,
    input  logic [DW-1:0]       fft_d7,
    input  logic [DW-1:0]       fft_d8,
    input  logic [DW-1:0]       fft_d9,
    input  logic [DW-1:0]       fft_d10,
    input  logic [DW-1:0]       fft_d11,
    input  logic [DW-1:0]       fft_d12,
    input  logic [DW-1:0]       fft_d13,
    input  logic [DW-1:0]       fft_d14,
    input  logic [DW-1:0]       fft_d15,
    fft_frame_sched_if.master   bin,
    output logic                ovf,
    output logic                busy
`ifdef FAS_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0]   drop_cnt
`endif
);

    import fas_pkg::*;

    state_t                   state, state_n;
    logic [1:0]               full, full_n;
    logic                     wr_sel, rd_sel;
    logic [3:0]               idx;
    logic [NBINS-1:0][DW-1:0] frame_in;
    logic [DW-1:0]            rdata0, rdata1, rd_data;
    logic                     capture, drop, handshake, frame_done, stream_c;

    assign frame_in = {fft_d15, fft_d14, fft_d13, fft_d12, fft_d11, fft_d10, fft_d9, fft_d8,
                       fft_d7,  fft_d6,  fft_d5,  fft_d4,  fft_d3,  fft_d2,  fft_d1, fft_d0};

    // Accept/drop decisions look only at registered full flags, so a buffer
    // being released this cycle still counts as occupied.
    assign capture    = fft_valid && !full[wr_sel] && !rst;
    assign drop       = fft_valid &&  full[wr_sel];
    assign handshake  = (state == S_STREAM) && bin.bin_ready;
    assign frame_done = handshake && (idx == 4'd15);

    fft_frame_buf #(.DW(DW), .NBINS(NBINS)) u_buf0 (
        .clk   (clk),
        .we    (capture && !wr_sel),
        .wdata (frame_in),
        .ridx  (idx),
        .rdata (rdata0)
    );

    fft_frame_buf #(.DW(DW), .NBINS(NBINS)) u_buf1 (
        .clk   (clk),
        .we    (capture && wr_sel),
        .wdata (frame_in),
        .ridx  (idx),
        .rdata (rdata1)
    );

    assign rd_data = rd_sel ? rdata1 : rdata0;

    // Next-state uses post-update flags so a fresh capture streams on the next
    // cycle and the hand-over to the other buffer has no bubble.
    always_comb begin
        full_n   = full;
        state_n  = state;
        stream_c = 1'b0;
        if (frame_done) full_n[rd_sel] = 1'b0;
        if (capture)    full_n[wr_sel] = 1'b1;
        case (state)
            S_IDLE: begin
                if (full_n[rd_sel]) state_n = S_STREAM;
            end
            S_STREAM: begin
                stream_c = 1'b1;
                if (frame_done && !full_n[~rd_sel]) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            full   <= 2'b00;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            idx    <= 4'd0;
            ovf    <= 1'b0;
        end else begin
            state <= state_n;
            full  <= full_n;
            ovf   <= drop;
            if (capture) wr_sel <= ~wr_sel;
            if (frame_done) begin
                rd_sel <= ~rd_sel;
                idx    <= 4'd0;
            end else if (handshake) begin
                idx <= idx + 4'd1;
            end
        end
    end

    assign bin.bin_valid = stream_c;
    assign bin.bin_idx   = idx;
    assign bin.bin_data  = stream_c ? rd_data : '0;
    assign bin.bin_last  = stream_c && (idx == 4'd15);
    assign busy          = full[0] || full[1];

`ifdef FAS_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != {DROP_W{1'b1}})) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`else
    logic unused_drop_w;
    assign unused_drop_w = DROP_W[0];
`endif

endmodule

// File: tb/tb_fft_frame_sched.sv
// tb/tb_fft_frame_sched.sv - directed + random checks of fft_frame_sched against a frame-queue model
module tb_fft_frame_sched;

    import fas_pkg::*;

    typedef logic [15:0][31:0] frame_t;

    logic        clk;
    logic        rst;
    logic        fft_valid;
    logic [31:0] fft_d [16];
    logic        ovf;
    logic        busy;
`ifdef FAS_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    fft_frame_sched_if #(.DW(32)) bin_if ();

    fft_frame_sched #(.DW(32), .NBINS(16), .DROP_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .fft_valid (fft_valid),
        .fft_d0    (fft_d[0]),
        .fft_d1    (fft_d[1]),
        .fft_d2    (fft_d[2]),
        .fft_d3    (fft_d[3]),
        .fft_d4    (fft_d[4]),
        .fft_d5    (fft_d[5]),
        .fft_d6    (fft_d[6]),
        .fft_d7    (fft_d[7]),
        .fft_d8    (fft_d[8]),
        .fft_d9    (fft_d[9]),
        .fft_d10   (fft_d[10]),
        .fft_d11   (fft_d[11]),
        .fft_d12   (fft_d[12]),
        .fft_d13   (fft_d[13]),
        .fft_d14   (fft_d[14]),
        .fft_d15   (fft_d[15]),
        .bin       (bin_if.master),
        .ovf       (ovf),
        .busy      (busy)
`ifdef FAS_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    int     checks = 0;
    int     passed = 0;
    int     fails  = 0;
    int     cyc    = 0;

    frame_t stored[$];
    int     pos     = 0;
    logic   exp_ovf = 1'b0;
    int     drops   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        frame_t      head;
        logic        ev;
        logic [31:0] ed;
        ev = (stored.size() > 0);
        ed = 32'h0;
        if (ev) begin
            head = stored[0];
            ed   = head[pos];
        end
        chk("bin_valid", {31'h0, bin_if.bin_valid}, {31'h0, ev});
        chk("bin_idx",   {28'h0, bin_if.bin_idx},   ev ? 32'(pos) : 32'h0);
        chk("bin_data",  bin_if.bin_data,           ed);
        chk("bin_last",  {31'h0, bin_if.bin_last},  {31'h0, ev && (pos == 15)});
        chk("busy",      {31'h0, busy},             {31'h0, ev});
        chk("ovf",       {31'h0, ovf},              {31'h0, exp_ovf});
`ifdef FAS_DROP_CNT_EN
        chk("drop_cnt",  {24'h0, drop_cnt},         32'(drops));
`endif
    endtask

    // mode: 0 random bins, 1 ramp k*0x0001_0000
    task automatic cycle(input logic v, input logic r, input logic do_rst, input int mode);
        frame_t f;
        bin_t   b;
        logic   hs, dr;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            if (mode == 1) begin
                b.re     = 16'(k);
                b.im     = 16'h0;
                fft_d[k] = b;
            end else begin
                fft_d[k] = $urandom;
            end
            f[k] = fft_d[k];
        end
        fft_valid        = v;
        bin_if.bin_ready = r;
        rst              = do_rst;
        if (do_rst) begin
            stored.delete();
            pos     = 0;
            exp_ovf = 1'b0;
            drops   = 0;
        end else begin
            hs      = (stored.size() > 0) && r;
            dr      = v && (stored.size() == 2);
            exp_ovf = dr;
            if (dr && drops != 255) drops = drops + 1;
            if (v && !dr) stored.push_back(f);
            if (hs) begin
                pos = pos + 1;
                if (pos == 16) begin
                    void'(stored.pop_front());
                    pos = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        check_all();
    endtask

    initial begin : main
        int   t0, lat, run, stalls, ovfs;
        logic r, seen, ended;

        rst              = 1'b1;
        fft_valid        = 1'b0;
        bin_if.bin_ready = 1'b1;
        for (int k = 0; k < 16; k++) fft_d[k] = 32'h0;

        // Reset, including a frame offered during reset which must be ignored
        cycle(1'b0, 1'b1, 1'b1, 0);
        cycle(1'b1, 1'b1, 1'b1, 0);
        cycle(1'b0, 1'b1, 1'b0, 0);
        chk("reset_busy", {31'h0, busy}, 32'h0);

        // Single ramp frame at full rate
        cycle(1'b1, 1'b1, 1'b0, 1);
        t0 = cyc;
        chk("lat_first_idx", {28'h0, bin_if.bin_idx}, 32'h0);
        chk("lat_first_valid", {31'h0, bin_if.bin_valid}, 32'h1);
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (bin_if.bin_last) begin
                seen = 1'b1;
                lat  = cyc - t0 + 1;
            end else begin
                cycle(1'b0, 1'b1, 1'b0, 0);
            end
        end
        chk("single_last_cycle", 32'(lat), 32'd16);
        cycle(1'b0, 1'b1, 1'b0, 0);
        chk("single_busy_after", {31'h0, busy}, 32'h0);

        // Backpressure: three stall cycles on bin 5
        cycle(1'b1, 1'b1, 1'b0, 0);
        t0     = cyc;
        stalls = 0;
        seen   = 1'b0;
        lat    = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bin_if.bin_last) begin
                seen = 1'b1;
                lat  = cyc - t0 + 1;
            end else begin
                r = !(pos == 5 && stalls < 3);
                if (!r) stalls = stalls + 1;
                cycle(1'b0, r, 1'b0, 0);
            end
        end
        chk("bp_last_cycle", 32'(lat), 32'd19);
        cycle(1'b0, 1'b1, 1'b0, 0);

        // Back-to-back frames two cycles apart
        cycle(1'b1, 1'b1, 1'b0, 0);
        run   = (bin_if.bin_valid) ? 1 : 0;
        ended = 1'b0;
        cycle(1'b0, 1'b1, 1'b0, 0);
        if (bin_if.bin_valid) run = run + 1;
        cycle(1'b1, 1'b1, 1'b0, 0);
        if (bin_if.bin_valid) run = run + 1;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 0);
            if (bin_if.bin_valid && !ended) run = run + 1;
            else if (!bin_if.bin_valid) ended = 1'b1;
        end
        chk("b2b_run_len", 32'(run), 32'd32);

        // Overflow: three frames with downstream stalled
        ovfs = 0;
        cycle(1'b1, 1'b0, 1'b0, 0);
        cycle(1'b1, 1'b0, 1'b0, 0);
        cycle(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 45; i++) begin
            if (ovf) ovfs = ovfs + 1;
            cycle(1'b0, (i > 3), 1'b0, 0);
        end
        chk("ovf_pulses", 32'(ovfs), 32'd1);
`ifdef FAS_DROP_CNT_EN
        chk("ovf_drop_cnt", {24'h0, drop_cnt}, 32'd1);
`endif

        // Release and capture in the same cycle with both buffers full
        cycle(1'b1, 1'b0, 1'b0, 0);
        cycle(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 20 && pos != 15; i++) cycle(1'b0, 1'b1, 1'b0, 0);
        cycle(1'b1, 1'b1, 1'b0, 0);
        chk("same_cycle_ovf", {31'h0, ovf}, 32'h1);

        // Reset mid-stream at bin 7 of the second frame
        for (int i = 0; i < 20 && pos != 7; i++) cycle(1'b0, 1'b1, 1'b0, 0);
        cycle(1'b0, 1'b1, 1'b1, 0);
        chk("rst_mid_valid", {31'h0, bin_if.bin_valid}, 32'h0);
        chk("rst_mid_idx",   {28'h0, bin_if.bin_idx},   32'h0);
        chk("rst_mid_data",  bin_if.bin_data,           32'h0);
        chk("rst_mid_busy",  {31'h0, busy},             32'h0);
        cycle(1'b0, 1'b1, 1'b0, 0);
        chk("rst_mid_after", {31'h0, bin_if.bin_valid}, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0), 1'b0, 0);
        end
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 1'b0, 0);
        chk("final_busy", {31'h0, busy}, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
